synapse_loader: RTL and testbench

SYNAPSE_LOADER -- requirements
Module: synapse_loader

---
 rtl/synapse_loader.sv | 134 +++++++++++++
 tb/tb_synapse_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/synapse_loader.sv
// Synapse weight loader: streams host weights into the network's
// synapse programming port as bounded, abortable bursts.
module synapse_loader #(
  parameter int NEURONS_PER_LAYER = 4,
  parameter int SYNAPSE_WIDTH = 8,
  localparam int NSYN = NEURONS_PER_LAYER * NEURONS_PER_LAYER,
  localparam int AW = $clog2(NSYN),
  localparam int CW = $clog2(NSYN + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [AW-1:0]                   start_addr,
  input  logic [CW-1:0]                   count,
  input  logic                            abort,
  input  logic                            s_valid,
  input  logic signed [SYNAPSE_WIDTH-1:0] s_data,
  output logic                            s_ready,
  output logic                            synapse_prog_en,
  output logic [AW-1:0]                   synapse_addr,
  output logic signed [SYNAPSE_WIDTH-1:0] synapse_data,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic                            aborted
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic prog_en_q, prog_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic signed [SYNAPSE_WIDTH-1:0] data_q, data_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic aborted_q, aborted_d;

  logic [CW:0] end_sum;
  logic range_bad;
  logic xfer;

  // one extra bit so start_addr+count cannot wrap
  assign end_sum = (CW+1)'(start_addr) + (CW+1)'(count);
  assign range_bad = (count == '0) || (end_sum > (CW+1)'(NSYN));

  assign s_ready = (state_q == LOAD) && !abort;
  assign xfer = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    cur_addr_d = cur_addr_q;
    remaining_d = remaining_q;
    prog_en_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    done_d = 1'b0;
    error_d = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (range_bad) begin
            error_d = 1'b1;
          end else begin
            cur_addr_d = start_addr;
            remaining_d = count;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d = IDLE;
        end else if (xfer) begin
          prog_en_d = 1'b1;
          addr_d = cur_addr_q;
          data_d = s_data;
          remaining_d = remaining_q - CW'(1);
          // last word: hold cur_addr so it never passes NSYN-1
          if (remaining_q == CW'(1)) begin
            state_d = DONE;
          end else begin
            cur_addr_d = cur_addr_q + AW'(1);
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_addr_q <= '0;
      remaining_q <= '0;
      prog_en_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_addr_q <= cur_addr_d;
      remaining_q <= remaining_d;
      prog_en_q <= prog_en_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
      aborted_q <= aborted_d;
    end
  end

  assign synapse_prog_en = prog_en_q;
  assign synapse_addr = addr_q;
  assign synapse_data = data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_synapse_loader.sv
// Bench for synapse_loader: burst-level reference model checked
// every cycle, directed scenarios pinned with literal write logs.
module tb_synapse_loader;

  localparam int N = 4;
  localparam int SW = 8;
  localparam int NSYN = N * N;
  localparam int AW = $clog2(NSYN);
  localparam int CW = $clog2(NSYN + 1);

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] count;
  logic abort;
  logic s_valid;
  logic signed [SW-1:0] s_data;
  logic s_ready;
  logic synapse_prog_en;
  logic [AW-1:0] synapse_addr;
  logic signed [SW-1:0] synapse_data;
  logic busy, done, error, aborted;

  synapse_loader #(.NEURONS_PER_LAYER(N), .SYNAPSE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .count(count), .abort(abort), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .synapse_prog_en(synapse_prog_en),
    .synapse_addr(synapse_addr), .synapse_data(synapse_data),
    .busy(busy), .done(done), .error(error), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference: a burst is "open" between an accepted start and its
  // final word; bookkeeping is next address and words still owed.
  int m_phase = 0;   // 0 none, 1 open, 2 complete awaiting done
  int m_next = 0;
  int m_left = 0;
  int e_prog = 0, e_addr = 0, e_data = 0;
  int e_done = 0, e_err = 0, e_abt = 0, e_busy = 0;

  always @(posedge clk) begin
    e_prog = 0; e_done = 0; e_err = 0; e_abt = 0;
    if (rst) begin
      m_phase = 0; m_next = 0; m_left = 0; e_addr = 0; e_data = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        if (count == 0 || int'(start_addr) + int'(count) > NSYN) e_err = 1;
        else begin m_phase = 1; m_next = int'(start_addr); m_left = int'(count); end
      end
    end else if (m_phase == 1) begin
      if (abort) begin e_abt = 1; m_phase = 0; end
      else if (s_valid) begin
        e_prog = 1; e_addr = m_next; e_data = int'(s_data);
        m_left--;
        if (m_left == 0) m_phase = 2; else m_next++;
      end
    end else begin
      e_done = 1; m_phase = 0;
    end
    e_busy = (m_phase != 0) ? 1 : 0;
  end

  // DUT observation log
  int la[$];
  int ld[$];
  int cyc_n = 0, first_s = -1, last_s = -1, done_c = -1;
  int done_n = 0, err_n = 0, abt_n = 0, busy_seen = 0;

  always @(negedge clk) begin
    cyc_n++;
    chk("s_ready", int'(s_ready), (m_phase == 1 && !abort) ? 1 : 0);
    chk("prog_en", int'(synapse_prog_en), e_prog);
    chk("addr", int'(synapse_addr), e_addr);
    chk("data", int'(synapse_data), e_data);
    chk("busy", int'(busy), e_busy);
    chk("done", int'(done), e_done);
    chk("error", int'(error), e_err);
    chk("aborted", int'(aborted), e_abt);
    if (synapse_prog_en) begin
      la.push_back(int'(synapse_addr));
      ld.push_back(int'(synapse_data));
      if (first_s < 0) first_s = cyc_n;
      last_s = cyc_n;
    end
    if (done) begin done_n++; done_c = cyc_n; end
    if (error) err_n++;
    if (aborted) abt_n++;
    if (busy) busy_seen = 1;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    la.delete(); ld.delete();
    first_s = -1; last_s = -1; done_c = -1;
    done_n = 0; err_n = 0; abt_n = 0; busy_seen = 0;
  endtask

  task automatic go(input int a, input int c);
    start = 1; start_addr = AW'(a); count = CW'(c);
    cyc();
    start = 0;
  endtask

  task automatic feed(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1; s_data = SW'(base + i); cyc();
    end
    s_valid = 0;
  endtask

  task automatic chk_log(input string nm, input int a0, input int n);
    chk({nm, "_len"}, la.size(), n);
    for (int i = 0; i < n && i < la.size(); i++)
      chk({nm, "_addr"}, la[i], a0 + i);
  endtask

  int gv[5] = '{1, 0, 1, 0, 1};
  int gd[5] = '{-3, 55, 7, 99, -128};

  initial begin
    rst = 1; start = 0; start_addr = '0; count = '0;
    abort = 0; s_valid = 0; s_data = '0;
    cyc(); cyc();
    @(negedge clk); #1;
    chk("rst_addr_lit", int'(synapse_addr), 0);
    chk("rst_busy_lit", int'(busy), 0);
    chk("rst_prog_lit", int'(synapse_prog_en), 0);
    @(posedge clk); #1;
    rst = 0;
    cyc();

    // full load
    clr(); go(0, 16); feed(16, 1); repeat (3) cyc();
    chk_log("full", 0, 16);
    for (int i = 0; i < 16 && i < ld.size(); i++) chk("full_data", ld[i], i + 1);
    chk("full_contig", last_s - first_s, 15);
    chk("full_done_n", done_n, 1);
    chk("full_done_lat", done_c - last_s, 1);

    // partial with gaps
    clr(); go(5, 3);
    for (int i = 0; i < 5; i++) begin
      s_valid = gv[i][0]; s_data = SW'(gd[i]); cyc();
    end
    s_valid = 0; repeat (3) cyc();
    chk_log("gap", 5, 3);
    if (ld.size() == 3) begin
      chk("gap_d0", ld[0], -3); chk("gap_d1", ld[1], 7); chk("gap_d2", ld[2], -128);
    end else chk("gap_dlen", ld.size(), 3);
    chk("gap_done_n", done_n, 1);

    // range errors
    clr(); go(14, 3); repeat (2) cyc();
    chk("rng_err", err_n, 1); chk("rng_busy", busy_seen, 0); chk("rng_len", la.size(), 0);
    clr(); go(13, 3); feed(3, 20); repeat (3) cyc();
    chk_log("edge", 13, 3);
    chk("edge_err", err_n, 0); chk("edge_done", done_n, 1);
    clr(); go(2, 0); repeat (2) cyc();
    chk("zero_err", err_n, 1); chk("zero_busy", busy_seen, 0);

    // abort
    clr(); go(0, 8); feed(3, 40);
    s_valid = 1; abort = 1;
    @(negedge clk); #1;
    chk("abt_ready_lit", int'(s_ready), 0);
    @(posedge clk); #1;
    abort = 0; s_valid = 0; repeat (3) cyc();
    chk_log("abt", 0, 3);
    chk("abt_n", abt_n, 1); chk("abt_done", done_n, 0);

    // reset mid-burst
    clr(); go(0, 10); feed(2, 60);
    rst = 1; s_valid = 1; cyc();
    rst = 0;
    @(negedge clk); #1;
    chk("mrst_addr_lit", int'(synapse_addr), 0);
    chk("mrst_data_lit", int'(synapse_data), 0);
    chk("mrst_busy_lit", int'(busy), 0);
    @(posedge clk); #1;
    s_valid = 1; cyc(); s_valid = 0;
    chk_log("mrst", 0, 2);
    chk("mrst_done", done_n, 0);
    clr(); go(9, 2); feed(2, 70); repeat (3) cyc();
    chk_log("mrst_new", 9, 2);

    // start while busy
    clr(); go(2, 4); feed(1, 80);
    start = 1; start_addr = AW'(10); count = CW'(2);
    s_valid = 1; s_data = SW'(81); cyc();
    start = 0; feed(2, 82); repeat (3) cyc();
    chk_log("sbusy", 2, 4);
    chk("sbusy_done", done_n, 1); chk("sbusy_err", err_n, 0);

    // randomized bursts
    for (int b = 0; b < 40; b++) begin
      go($urandom_range(0, NSYN - 1), $urandom_range(0, NSYN));
      for (int k = 0; k < 80 && m_phase != 0; k++) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data = SW'($urandom);
        abort = ($urandom_range(0, 40) == 0);
        start = ($urandom_range(0, 9) == 0);
        start_addr = AW'($urandom);
        count = CW'($urandom_range(0, NSYN));
        rst = ($urandom_range(0, 60) == 0);
        cyc();
      end
      chk("rnd_closed", m_phase, 0);
      start = 0; abort = 0; s_valid = 0; rst = 0;
      repeat (2) cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
